// File: rtl/rip_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers returned words with their PCs.
// Latency: grant in cycle t, rvalid in t+1, instruction offered to decode in t+2.
// Backpressure: stall holds the head slot; requests stop once DEPTH slots are allocated.
module rip_fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] NOP_CODE   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic        de_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = AW + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]    pc;
  logic [31:0]    slot_pc  [DEPTH];
  logic [31:0]    slot_dat [DEPTH];
  logic [DEPTH-1:0] slot_fill;
  logic [AW-1:0]  head, tail, fptr;
  logic [CW-1:0]  cnt;       // allocated slots
  logic [CW-1:0]  ucnt;      // allocated but still waiting for data
  logic [DW-1:0]  drop_cnt;  // responses still owed to requests flushed by a redirect
  logic [DW-1:0]  drop_redir;
  logic           alloc, pop, accept, discard;

  assign imem_req  = rst_n && !redirect && (cnt < FULL);
  assign imem_addr = pc;
  assign alloc     = imem_req && imem_gnt;
  assign de_ready  = (cnt != '0) && slot_fill[head] && !redirect;
  assign pop       = de_ready && !stall;
  assign discard   = imem_rvalid && (drop_cnt != '0);
  assign accept    = imem_rvalid && (drop_cnt == '0) && (ucnt != '0);
  assign inst_code = de_ready ? slot_dat[head] : NOP_CODE;
  assign inst_pc   = de_ready ? slot_pc[head]  : 32'h0;

  // Everything still in flight at a redirect is stale; a response landing in the
  // redirect cycle itself is one of those and is already consumed.
  always_comb begin
    drop_redir = drop_cnt + DW'(ucnt);
    if (imem_rvalid && (drop_redir != '0))
      drop_redir = drop_redir - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= START_ADDR;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      cnt       <= '0;
      ucnt      <= '0;
      drop_cnt  <= '0;
      slot_fill <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc[i]  <= 32'h0;
        slot_dat[i] <= 32'h0;
      end
    end else if (redirect) begin
      pc        <= {redirect_pc[31:2], 2'b00};
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      cnt       <= '0;
      ucnt      <= '0;
      slot_fill <= '0;
      drop_cnt  <= drop_redir;
    end else begin
      if (alloc) begin
        slot_pc[tail]   <= pc;
        slot_fill[tail] <= 1'b0;
        tail            <= tail + AW'(1);
        pc              <= pc + 32'd4;
      end
      if (accept) begin
        slot_dat[fptr]  <= imem_rdata;
        slot_fill[fptr] <= 1'b1;
        fptr            <= fptr + AW'(1);
      end
      if (discard)
        drop_cnt <= drop_cnt - DW'(1);
      if (pop)
        head <= head + AW'(1);

      if (alloc && !pop)
        cnt <= cnt + CW'(1);
      else if (!alloc && pop)
        cnt <= cnt - CW'(1);

      if (alloc && !accept)
        ucnt <= ucnt + CW'(1);
      else if (!alloc && accept)
        ucnt <= ucnt - CW'(1);
    end
  end

endmodule

// File: doc/rip_fetch.md
Name: rip_fetch

Overview:
Instruction fetch stage directly upstream of the decode stage. Holds the PC, issues in-order requests to the instruction memory port, and buffers returned words with their PCs in a small slot queue. Presents one instruction per cycle to decode as inst_code / inst_pc with a de_ready valid flag. Execute can redirect it on branch, jump or trap, which flushes the queue.

Parameters:
START_ADDR, 32'h0000_0000, PC value loaded at reset
DEPTH, 4, number of buffer slots (power of 2, >=2); bounds outstanding requests plus buffered words
NOP_CODE, 32'h0000_0013, inst_code driven when no valid instruction (ADDI x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request (combinational)
imem_addr  out  32  request address = pc register, bits[1:0] always 0
imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req)
imem_rvalid  in  1  read data returned; responses strictly in request order
imem_rdata  in  32  returned instruction word
redirect  in  1  flush and restart fetch (from execute / trap logic)
redirect_pc  in  32  new fetch address; bits[1:0] ignored (forced 0)
stall  in  1  downstream holds current instruction (ex_stall)
inst_code  out  32  instruction to decode
inst_pc  out  32  PC of inst_code
de_ready  out  1  inst_code/inst_pc valid this cycle

Behaviour:
- Reset (async, rst_n=0): pc=START_ADDR, all slots empty, head=tail=0, drop_cnt=0; outputs imem_req=0, de_ready=0, inst_code=NOP_CODE, inst_pc=0. Release takes effect from the first rising edge with rst_n=1.
- Slot = {pc, data, filled}. A slot is allocated at tail on imem_req&&imem_gnt, storing pc, with filled=0, and pc<=pc+4 (32-bit wrap). Responses fill the oldest allocated-unfilled slot and set filled=1 on the next edge.
- imem_req = !redirect && (allocated slots < DEPTH). The pc register is the address, so a withdrawn, ungranted request may change address after a redirect.
- de_ready = head slot allocated && filled && !redirect. inst_code/inst_pc come from the head slot; when !de_ready, inst_code=NOP_CODE and inst_pc=0.
- Pop: the head is freed at the edge where de_ready && !stall. The freed slot is usable for allocation the next cycle (no same-cycle reuse).
- Latency: gnt at cycle t, rvalid at t+1 gives de_ready at t+2. With DEPTH>=3 and single-cycle memory, throughput is 1 instruction/cycle.
- Redirect (priority over everything): on that edge pc<=redirect_pc&~3, all slots freed, head=tail=0. drop_cnt<=(number of allocated-unfilled slots) minus 1 if imem_rvalid in the same cycle. The same-cycle rvalid is discarded, and no pop or allocate occurs.
- While drop_cnt!=0, each imem_rvalid decrements drop_cnt and is discarded, not written to a slot. New requests may already be issued; in-order return guarantees stale data drains first.
- Full: allocated==DEPTH gives imem_req=0. Empty or head unfilled gives de_ready=0.
- stall with empty queue has no effect. stall does not block redirect.
- Reset mid-operation: all state is cleared immediately. Responses still in flight after reset are the memory's responsibility (the memory shares rst_n).

Test Plan:
- Reset release, memory gnt=1 always, rvalid 1 cycle later returning addr as data: imem_addr 0,4,8,... on consecutive cycles; de_ready from cycle 2 continuously; inst_pc 0,4,8 with inst_code==inst_pc.
- stall=1 for 3 cycles at inst_pc=8: inst_code/inst_pc hold at 8. imem_req drops once 4 slots are allocated. After release, 12,16,... follow with no loss or duplication.
- redirect=1, redirect_pc=32'h103 with 2 responses in flight: de_ready=0 that cycle, next imem_addr=0x100, the 2 stale rvalids are discarded. First delivered inst_pc=0x100.
- redirect in the same cycle as an imem_rvalid with 1 outstanding: drop_cnt=0, no stale instruction is ever presented, fetch resumes at redirect_pc.
- Random gnt (50%) and variable rvalid delay (1–4 cycles) with 200 instructions: delivered PC sequence strictly +4 except at redirects, and each inst_code matches its address.
- Async reset asserted mid-stream between clock edges: de_ready=0, imem_req=0 and inst_code=NOP_CODE immediately. After release, fetch restarts at START_ADDR.
